cdb_arbiter: RTL and testbench

Arbiter and write-back sequencer for the Common Data Bus of the Tomasulo core. Up to NREQ completing reservation stations and functional units request the bus. One winner per cycle is picked round-robin and its result is broadcast for one cycle with its tag. The block also drives the register-file write port (ADD.D/SUB.D/MUL.D/L.D results) or the memory write request (S.D), replacing the ad-hoc `posedge done` write-back path.

---
 rtl/cdb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Round-robin Common Data Bus arbiter with register-file / memory
//             write-back decode for the Tomasulo core.
//  Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int TAGW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [4*NREQ-1:0]     req_op,
    input  logic [3*NREQ-1:0]     req_dest,
    input  logic [WIDTH*NREQ-1:0] req_data,
    input  logic                  hold,
    output logic [NREQ-1:0]       grant,
    output logic                  cdb_valid,
    output logic [TAGW-1:0]       cdb_tag,
    output logic [WIDTH-1:0]      cdb_data,
    output logic                  rf_we,
    output logic [2:0]            rf_addr,
    output logic [WIDTH-1:0]      rf_data,
    output logic [5:0]            ld_addr,
    output logic                  mem_we,
    output logic [5:0]            mem_addr,
    output logic [2:0]            mem_src,
    output logic                  illegal_op
);

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_MUL = 4'b0100;
    localparam logic [3:0] c_OP_LD  = 4'b0010;
    localparam logic [3:0] c_OP_SD  = 4'b0011;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BCAST = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [TAGW-1:0]   r_last;
    logic [TAGW-1:0]   w_winner;
    logic [TAGW-1:0]   w_idx;
    logic              w_found;
    logic              w_grantEn;
    logic [3:0]        w_op;
    logic [2:0]        w_dest;
    logic [WIDTH-1:0]  w_data;
    logic              w_isArith;
    logic              w_isLd;
    logic              w_isSd;

    logic [TAGW-1:0]   r_cdbTag;
    logic [WIDTH-1:0]  r_cdbData;
    logic              r_rfWe;
    logic [2:0]        r_rfAddr;
    logic [WIDTH-1:0]  r_rfData;
    logic [5:0]        r_ldAddr;
    logic              r_memWe;
    logic [5:0]        r_memAddr;
    logic [2:0]        r_memSrc;
    logic              r_illegal;

    // Scan from the farthest candidate back to the nearest so the nearest
    // requester after r_last is the one left standing.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = NREQ; i >= 1; i--) begin
            w_idx = TAGW'((int'(r_last) + i) % NREQ);
            if (req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_grantEn = rst_n & ~hold & w_found;
    assign grant     = w_grantEn ? (NREQ'(1) << w_winner) : '0;

    always_comb begin
        w_op   = '0;
        w_dest = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (TAGW'(i) == w_winner) begin
                w_op   = req_op[4*i +: 4];
                w_dest = req_dest[3*i +: 3];
                w_data = req_data[WIDTH*i +: WIDTH];
            end
        end
    end

    assign w_isArith = (w_op == c_OP_ADD) || (w_op == c_OP_SUB) || (w_op == c_OP_MUL);
    assign w_isLd    = (w_op == c_OP_LD);
    assign w_isSd    = (w_op == c_OP_SD);

    always_comb begin
        w_nextState = IDLE;
        if (w_grantEn) begin
            w_nextState = BCAST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last    <= TAGW'(NREQ - 1);
            r_cdbTag  <= '0;
            r_cdbData <= '0;
            r_rfWe    <= 1'b0;
            r_rfAddr  <= '0;
            r_rfData  <= '0;
            r_ldAddr  <= '0;
            r_memWe   <= 1'b0;
            r_memAddr <= '0;
            r_memSrc  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_rfWe  <= 1'b0;
            r_memWe <= 1'b0;
            if (w_grantEn) begin
                r_last    <= w_winner;
                r_cdbTag  <= w_winner;
                r_cdbData <= w_data;
                if (w_isArith || w_isLd) begin
                    // There is no R0, so a zero destination broadcasts only.
                    r_rfWe   <= (w_dest != 3'd0);
                    r_rfAddr <= w_dest;
                    r_rfData <= w_data;
                end
                if (w_isLd) begin
                    r_ldAddr <= w_data[5:0];
                end
                if (w_isSd) begin
                    r_memWe   <= 1'b1;
                    r_memAddr <= w_data[5:0];
                    r_memSrc  <= w_dest;
                end
                if (!(w_isArith || w_isLd || w_isSd)) begin
                    r_illegal <= 1'b1;
                end
            end
        end
    end

    assign cdb_valid  = (r_state == BCAST);
    assign cdb_tag    = r_cdbTag;
    assign cdb_data   = r_cdbData;
    assign rf_we      = r_rfWe;
    assign rf_addr    = r_rfAddr;
    assign rf_data    = r_rfData;
    assign ld_addr    = r_ldAddr;
    assign mem_we     = r_memWe;
    assign mem_addr   = r_memAddr;
    assign mem_src    = r_memSrc;
    assign illegal_op = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Self-checking bench for cdb_arbiter: directed scenarios plus a
//             randomized requester population against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int TAGW  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [4*NREQ-1:0]     req_op;
    logic [3*NREQ-1:0]     req_dest;
    logic [WIDTH*NREQ-1:0] req_data;
    logic                  hold;
    logic [NREQ-1:0]       grant;
    logic                  cdb_valid;
    logic [TAGW-1:0]       cdb_tag;
    logic [WIDTH-1:0]      cdb_data;
    logic                  rf_we;
    logic [2:0]            rf_addr;
    logic [WIDTH-1:0]      rf_data;
    logic [5:0]            ld_addr;
    logic                  mem_we;
    logic [5:0]            mem_addr;
    logic [2:0]            mem_src;
    logic                  illegal_op;

    cdb_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_dest(req_dest),
        .req_data(req_data), .hold(hold), .grant(grant), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .rf_we(rf_we), .rf_addr(rf_addr),
        .rf_data(rf_data), .ld_addr(ld_addr), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_src(mem_src), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;
    int modelLast;
    logic modelIllegal;

    logic             reqV  [NREQ];
    logic [3:0]       opA   [NREQ];
    logic [2:0]       destA [NREQ];
    logic [WIDTH-1:0] dataA [NREQ];

    function automatic int rrPick(int lastIdx, logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(lastIdx + k) % NREQ]) return (lastIdx + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i]               = reqV[i];
            req_op[4*i +: 4]     = opA[i];
            req_dest[3*i +: 3]   = destA[i];
            req_data[WIDTH*i +: WIDTH] = dataA[i];
        end
    endtask

    task automatic setReq(int i, logic [3:0] op, logic [2:0] dest, logic [WIDTH-1:0] data);
        reqV[i] = 1'b1; opA[i] = op; destA[i] = dest; dataA[i] = data;
    endtask

    task automatic newReq(int i);
        logic [3:0] legalOps [5];
        int k;
        legalOps = '{4'b0000, 4'b0001, 4'b0100, 4'b0010, 4'b0011};
        k = int'($urandom_range(0, 59));
        reqV[i]  = 1'b1;
        opA[i]   = (k == 0) ? 4'($urandom_range(5, 15)) : legalOps[k % 5];
        destA[i] = 3'($urandom_range(0, 7));
        dataA[i] = WIDTH'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hold = 1'b0;
        for (int i = 0; i < NREQ; i++) setReq(i, 4'b0000, 3'(i + 1), 16'h1000 + 16'(i));
        drive();
        repeat (2) @(posedge clk);
        #1;
        nChecks++; if (grant !== 4'b0000) begin nFails++; $display("FAIL reset_grant: got %b want 0000", grant); end
        nChecks++; if (cdb_valid !== 1'b0) begin nFails++; $display("FAIL reset_cdb_valid: got %b want 0", cdb_valid); end
        nChecks++; if (rf_we !== 1'b0 || mem_we !== 1'b0) begin nFails++; $display("FAIL reset_we: got rf_we=%b mem_we=%b want 0 0", rf_we, mem_we); end
        nChecks++; if (illegal_op !== 1'b0) begin nFails++; $display("FAIL reset_illegal: got %b want 0", illegal_op); end
        nChecks++; if (cdb_tag !== 2'd0 || cdb_data !== 16'h0) begin nFails++; $display("FAIL reset_cdb_fields: got tag=%0d data=%h want 0 0", cdb_tag, cdb_data); end
        nChecks++; if (rf_addr !== 3'd0 || rf_data !== 16'h0 || ld_addr !== 6'd0 || mem_addr !== 6'd0 || mem_src !== 3'd0) begin
            nFails++; $display("FAIL reset_addr_fields: got rf_addr=%0d rf_data=%h ld_addr=%0d mem_addr=%0d mem_src=%0d want all 0", rf_addr, rf_data, ld_addr, mem_addr, mem_src);
        end
        @(negedge clk); rst_n = 1'b1;
        #1;
        nChecks++; if (grant !== 4'b0001) begin nFails++; $display("FAIL reset_first_grant: got %b want 0001", grant); end
        @(posedge clk); #1;
        nChecks++; if (cdb_valid !== 1'b1 || cdb_tag !== 2'd0) begin nFails++; $display("FAIL reset_first_bcast: got valid=%b tag=%0d want 1 0", cdb_valid, cdb_tag); end
        nChecks++; if (rf_we !== 1'b1 || rf_addr !== 3'd1 || rf_data !== 16'h1000) begin nFails++; $display("FAIL reset_first_wb: got we=%b addr=%0d data=%h want 1 1 1000", rf_we, rf_addr, rf_data); end
        #2 rst_n = 1'b0;
        #1;
        nChecks++; if (cdb_valid !== 1'b0 || rf_we !== 1'b0 || grant !== 4'b0000) begin
            nFails++; $display("FAIL reset_midbcast: got valid=%b rf_we=%b grant=%b want 0 0 0000", cdb_valid, rf_we, grant);
        end
        modelLast = NREQ - 1;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int cnt [NREQ];
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        for (int k = 0; k < 8; k++) begin
            drive();
            #1;
            nChecks++; if (grant !== (NREQ'(1) << (k % NREQ))) begin nFails++; $display("FAIL rr_grant[%0d]: got %b want %b", k, grant, NREQ'(1) << (k % NREQ)); end
            for (int i = 0; i < NREQ; i++) if (grant[i]) cnt[i]++;
            @(posedge clk); #1;
            nChecks++; if (cdb_valid !== 1'b1 || cdb_tag !== TAGW'(k % NREQ)) begin nFails++; $display("FAIL rr_tag[%0d]: got valid=%b tag=%0d want 1 %0d", k, cdb_valid, cdb_tag, k % NREQ); end
            modelLast = k % NREQ;
            dataA[k % NREQ] = WIDTH'($urandom);
        end
        for (int i = 0; i < NREQ; i++) begin
            nChecks++; if (cnt[i] != 2) begin nFails++; $display("FAIL rr_count[%0d]: got %0d want 2", i, cnt[i]); end
        end
        for (int i = 0; i < NREQ; i++) reqV[i] = 1'b0;
        drive();
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        setReq(2, 4'b0000, 3'd5, 16'h00AB); drive(); #1;
        nChecks++; if (grant !== 4'b0100) begin nFails++; $display("FAIL dec_add_grant: got %b want 0100", grant); end
        @(posedge clk); #1;
        nChecks++; if (rf_we !== 1'b1 || rf_addr !== 3'd5 || rf_data !== 16'h00AB || mem_we !== 1'b0 || cdb_tag !== 2'd2) begin
            nFails++; $display("FAIL dec_add: got rf_we=%b addr=%0d data=%h mem_we=%b tag=%0d want 1 5 00ab 0 2", rf_we, rf_addr, rf_data, mem_we, cdb_tag);
        end
        reqV[2] = 1'b0;
        setReq(1, 4'b0011, 3'd3, 16'h0010); drive(); #1;
        nChecks++; if (grant !== 4'b0010) begin nFails++; $display("FAIL dec_sd_grant: got %b want 0010", grant); end
        @(posedge clk); #1;
        nChecks++; if (mem_we !== 1'b1 || mem_addr !== 6'd16 || mem_src !== 3'd3 || rf_we !== 1'b0 || cdb_tag !== 2'd1) begin
            nFails++; $display("FAIL dec_sd: got mem_we=%b addr=%0d src=%0d rf_we=%b tag=%0d want 1 16 3 0 1", mem_we, mem_addr, mem_src, rf_we, cdb_tag);
        end
        reqV[1] = 1'b0;
        setReq(0, 4'b0010, 3'd4, 16'h0025); drive();
        @(posedge clk); #1;
        nChecks++; if (rf_we !== 1'b1 || rf_addr !== 3'd4 || ld_addr !== 6'h25 || rf_data !== 16'h0025 || mem_we !== 1'b0) begin
            nFails++; $display("FAIL dec_ld: got rf_we=%b addr=%0d ld_addr=%h data=%h mem_we=%b want 1 4 25 0025 0", rf_we, rf_addr, ld_addr, rf_data, mem_we);
        end
        reqV[0] = 1'b0; drive();
        @(posedge clk); #1;
        nChecks++; if (cdb_valid !== 1'b0 || rf_we !== 1'b0 || mem_we !== 1'b0) begin
            nFails++; $display("FAIL dec_idle: got valid=%b rf_we=%b mem_we=%b want 0 0 0", cdb_valid, rf_we, mem_we);
        end
        modelLast = 0;
    endtask

    task automatic test_boundaries();
        setReq(3, 4'b0000, 3'd0, 16'h1234); drive();
        @(posedge clk); #1;
        nChecks++; if (cdb_valid !== 1'b1 || rf_we !== 1'b0 || cdb_tag !== 2'd3 || cdb_data !== 16'h1234) begin
            nFails++; $display("FAIL bnd_dest0: got valid=%b rf_we=%b tag=%0d data=%h want 1 0 3 1234", cdb_valid, rf_we, cdb_tag, cdb_data);
        end
        nChecks++; if (illegal_op !== 1'b0) begin nFails++; $display("FAIL bnd_illegal_pre: got %b want 0", illegal_op); end
        reqV[3] = 1'b0;
        setReq(1, 4'b1111, 3'd6, 16'h0F0F); drive();
        @(posedge clk); #1;
        nChecks++; if (illegal_op !== 1'b1 || cdb_valid !== 1'b1 || rf_we !== 1'b0 || mem_we !== 1'b0) begin
            nFails++; $display("FAIL bnd_illegal: got ill=%b valid=%b rf_we=%b mem_we=%b want 1 1 0 0", illegal_op, cdb_valid, rf_we, mem_we);
        end
        reqV[1] = 1'b0; drive();
        repeat (3) @(posedge clk);
        #1;
        nChecks++; if (illegal_op !== 1'b1 || cdb_valid !== 1'b0) begin nFails++; $display("FAIL bnd_illegal_sticky: got ill=%b valid=%b want 1 0", illegal_op, cdb_valid); end
        rst_n = 1'b0; #1;
        nChecks++; if (illegal_op !== 1'b0) begin nFails++; $display("FAIL bnd_illegal_clear: got %b want 0", illegal_op); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        modelLast = NREQ - 1;
        modelIllegal = 1'b0;
    endtask

    task automatic test_hold();
        setReq(1, 4'b0000, 3'd2, 16'h0111); drive(); #1;
        nChecks++; if (grant !== 4'b0010) begin nFails++; $display("FAIL hold_setup: got %b want 0010", grant); end
        @(posedge clk); #1;
        setReq(2, 4'b0001, 3'd3, 16'h0222);
        hold = 1'b1; drive();
        for (int k = 0; k < 3; k++) begin
            #1;
            nChecks++; if (grant !== 4'b0000) begin nFails++; $display("FAIL hold_grant[%0d]: got %b want 0000", k, grant); end
            @(posedge clk); #1;
            nChecks++; if (cdb_valid !== 1'b0) begin nFails++; $display("FAIL hold_valid[%0d]: got %b want 0", k, cdb_valid); end
        end
        hold = 1'b0; drive(); #1;
        nChecks++; if (grant !== 4'b0100) begin nFails++; $display("FAIL hold_release: got %b want 0100", grant); end
        @(posedge clk); #1;
        nChecks++; if (cdb_tag !== 2'd2 || cdb_valid !== 1'b1) begin nFails++; $display("FAIL hold_release_tag: got tag=%0d valid=%b want 2 1", cdb_tag, cdb_valid); end
        reqV[2] = 1'b0; drive(); #1;
        nChecks++; if (grant !== 4'b0010) begin nFails++; $display("FAIL hold_next: got %b want 0010", grant); end
        @(posedge clk); #1;
        reqV[1] = 1'b0; drive();
        modelLast = 1;
    endtask

    task automatic test_sparse_wrap();
        setReq(3, 4'b0100, 3'd7, 16'h3333); drive(); #1;
        nChecks++; if (grant !== 4'b1000) begin nFails++; $display("FAIL wrap_first: got %b want 1000", grant); end
        @(posedge clk); #1;
        dataA[3] = 16'h4444; drive(); #1;
        nChecks++; if (grant !== 4'b1000) begin nFails++; $display("FAIL wrap_self: got %b want 1000", grant); end
        @(posedge clk); #1;
        nChecks++; if (cdb_valid !== 1'b1 || cdb_tag !== 2'd3 || cdb_data !== 16'h4444) begin
            nFails++; $display("FAIL wrap_bcast: got valid=%b tag=%0d data=%h want 1 3 4444", cdb_valid, cdb_tag, cdb_data);
        end
        reqV[3] = 1'b0; drive();
        modelLast = 3;
    endtask

    task automatic test_random();
        int w;
        logic [NREQ-1:0] expG;
        logic [3:0] eOp;
        logic [2:0] eDest;
        logic [WIDTH-1:0] eData;
        logic eRfWe, eMemWe, eLegal;
        eOp = '0; eDest = '0; eData = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            hold = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < NREQ; i++) if (!reqV[i] && $urandom_range(0, 2) == 0) newReq(i);
            drive(); #1;
            w = hold ? -1 : rrPick(modelLast, req);
            expG = (w < 0) ? '0 : (NREQ'(1) << w);
            nChecks++; if (grant !== expG) begin nFails++; $display("FAIL rnd_grant[%0d]: got %b want %b", cyc, grant, expG); end
            if (w >= 0) begin eOp = opA[w]; eDest = destA[w]; eData = dataA[w]; end
            @(posedge clk); #1;
            nChecks++; if (cdb_valid !== (w >= 0)) begin nFails++; $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, cdb_valid, w >= 0); end
            if (w >= 0) begin
                eLegal = (eOp == 4'b0000) || (eOp == 4'b0001) || (eOp == 4'b0100) || (eOp == 4'b0010) || (eOp == 4'b0011);
                eRfWe  = ((eOp == 4'b0000) || (eOp == 4'b0001) || (eOp == 4'b0100) || (eOp == 4'b0010)) && (eDest != 3'd0);
                eMemWe = (eOp == 4'b0011);
                if (!eLegal) modelIllegal = 1'b1;
                nChecks++; if (cdb_tag !== TAGW'(w) || cdb_data !== eData) begin nFails++; $display("FAIL rnd_cdb[%0d]: got tag=%0d data=%h want %0d %h", cyc, cdb_tag, cdb_data, w, eData); end
                nChecks++; if (rf_we !== eRfWe || mem_we !== eMemWe) begin nFails++; $display("FAIL rnd_we[%0d]: got rf_we=%b mem_we=%b want %b %b op=%b", cyc, rf_we, mem_we, eRfWe, eMemWe, eOp); end
                if (eRfWe) begin
                    nChecks++; if (rf_addr !== eDest || rf_data !== eData) begin nFails++; $display("FAIL rnd_rf[%0d]: got addr=%0d data=%h want %0d %h", cyc, rf_addr, rf_data, eDest, eData); end
                end
                if (eMemWe) begin
                    nChecks++; if (mem_addr !== eData[5:0] || mem_src !== eDest) begin nFails++; $display("FAIL rnd_mem[%0d]: got addr=%0d src=%0d want %0d %0d", cyc, mem_addr, mem_src, eData[5:0], eDest); end
                end
                if (eOp == 4'b0010) begin
                    nChecks++; if (ld_addr !== eData[5:0]) begin nFails++; $display("FAIL rnd_ld[%0d]: got %0d want %0d", cyc, ld_addr, eData[5:0]); end
                end
                modelLast = w;
                if ($urandom_range(0, 1) == 0) reqV[w] = 1'b0;
                else newReq(w);
            end else begin
                nChecks++; if (rf_we !== 1'b0 || mem_we !== 1'b0) begin nFails++; $display("FAIL rnd_idle_we[%0d]: got rf_we=%b mem_we=%b want 0 0", cyc, rf_we, mem_we); end
            end
            nChecks++; if (illegal_op !== modelIllegal) begin nFails++; $display("FAIL rnd_illegal[%0d]: got %b want %b", cyc, illegal_op, modelIllegal); end
        end
    endtask

    initial begin
        modelLast    = NREQ - 1;
        modelIllegal = 1'b0;
        test_reset();
        test_round_robin();
        test_decode();
        test_boundaries();
        test_hold();
        test_sparse_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
